// File: rtl/decoder_package.sv
// rtl/decoder_package.sv - shared FSM state type and keypad map for the key decoder
package decoder_package;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DEBOUNCE = 3'd1,
        COMMIT   = 3'd2,
        HOLD     = 3'd3,
        RELEASE  = 3'd4
    } decoderstate;

    // Nibble (row*4 + col) holds the hex legend printed on that key.
    localparam logic [63:0] KEY_MAP = 64'hDF0E_C987_B654_A321;

    function automatic logic [1:0] onehot_to_index(input logic [3:0] v);
        logic [1:0] idx;
        idx = '0;
        for (int i = 0; i < 4; i++) begin
            if (v[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/key_lookup.sv
// rtl/key_lookup.sv - combinational one-hot row/column to hex key code
module key_lookup
    import decoder_package::*;
(
    input  logic [3:0] row,
    input  logic [3:0] col,
    output logic [3:0] code
);

    logic [5:0] bit_base;

    assign bit_base = {onehot_to_index(row), onehot_to_index(col), 2'b00};
    assign code     = KEY_MAP[bit_base +: 4];

endmodule

// File: rtl/key_decoder.sv
// rtl/key_decoder.sv - debounced 4x4 keypad decoder keeping the last two accepted keys
module key_decoder
    import decoder_package::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    input  logic [3:0] cols,
    input  logic       change,
    output logic [3:0] key_new,
    output logic [3:0] key_old,
    output logic       key_valid,
    output logic       busy
);

    localparam int             CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    decoderstate   state;
    logic [CW-1:0] counter;
    logic [3:0]    cap_row;
    logic [3:0]    cap_col;
    logic [3:0]    code;
    logic          press_ok;
    logic          match;
    logic          released;

    key_lookup u_lookup (
        .row  (cap_row),
        .col  (cap_col),
        .code (code)
    );

    assign press_ok  = change && $onehot(rows) && $onehot(cols);
    assign match     = (rows == cap_row) && (cols == cap_col);
    assign released  = (cols & cap_col) == 4'b0000;
    assign key_valid = (state == COMMIT);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            counter <= '0;
            cap_row <= '0;
            cap_col <= '0;
            key_new <= '0;
            key_old <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (press_ok) begin
                        cap_row <= rows;
                        cap_col <= cols;
                        counter <= '0;
                        state   <= DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (!match) begin
                        state <= IDLE;
                    end else if (counter == CNT_LAST) begin
                        state <= COMMIT;
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end
                COMMIT: begin
                    key_old <= key_new;
                    key_new <= code;
                    state   <= HOLD;
                end
                HOLD: begin
                    // Extra columns alongside the held one keep us here; only a full drop counts.
                    if (released) begin
                        counter <= '0;
                        state   <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (!released) begin
                        state <= HOLD;
                    end else if (counter == CNT_LAST) begin
                        state <= IDLE;
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_key_decoder.sv
// tb/tb_key_decoder.sv - directed self-checking bench for key_decoder
module tb_key_decoder;

    logic       clk;
    logic       reset;
    logic [3:0] rows;
    logic [3:0] cols;
    logic       change;
    logic [3:0] key_new;
    logic [3:0] key_old;
    logic       key_valid;
    logic       busy;

    int checks = 0;
    int passes = 0;

    key_decoder #(.DEBOUNCE_CYCLES(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .rows      (rows),
        .cols      (cols),
        .change    (change),
        .key_new   (key_new),
        .key_old   (key_old),
        .key_valid (key_valid),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic press(input string tag, input logic [3:0] r, input logic [3:0] c,
                         input logic [3:0] exp_new, input logic [3:0] exp_old);
        int n;
        rows   = r;
        cols   = c;
        change = 1'b1;
        tick();
        change = 1'b0;
        check({tag, ".busy"}, 32'(busy), 32'd1);
        n = 1;
        while (!key_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, ".latency"}, n, 32'd5);
        tick();
        check({tag, ".valid_pulse"}, 32'(key_valid), 32'd0);
        check({tag, ".key_new"}, 32'(key_new), 32'(exp_new));
        check({tag, ".key_old"}, 32'(key_old), 32'(exp_old));
    endtask

    task automatic release_key(input string tag);
        int n;
        bit seen;
        rows = 4'b0000;
        cols = 4'b0000;
        n    = 0;
        seen = 1'b0;
        while (busy && n < 20) begin
            tick();
            n++;
            if (key_valid) seen = 1'b1;
        end
        check({tag, ".release_cycles"}, n, 32'd5);
        check({tag, ".release_no_valid"}, 32'(seen), 32'd0);
    endtask

    initial begin
        bit seen;
        int n;
        reset  = 1'b1;
        rows   = 4'b0000;
        cols   = 4'b0000;
        change = 1'b0;
        tick();
        tick();
        check("reset.key_new", 32'(key_new), 32'd0);
        check("reset.key_old", 32'(key_old), 32'd0);
        check("reset.valid", 32'(key_valid), 32'd0);
        check("reset.busy", 32'(busy), 32'd0);
        reset = 1'b0;
        tick();

        press("key6", 4'b0010, 4'b0100, 4'h6, 4'h0);
        release_key("key6");
        press("key0", 4'b1000, 4'b0010, 4'h0, 4'h6);
        release_key("key0");

        // Bounce: column drops on the second debounce cycle
        rows   = 4'b0001;
        cols   = 4'b0001;
        change = 1'b1;
        tick();
        change = 1'b0;
        tick();
        cols = 4'b0000;
        tick();
        check("bounce.busy", 32'(busy), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (key_valid) seen = 1'b1;
        end
        check("bounce.no_valid", 32'(seen), 32'd0);
        check("bounce.key_new", 32'(key_new), 32'h0);
        check("bounce.key_old", 32'(key_old), 32'h6);

        // Second key while key 5 is held is never reported
        press("key5", 4'b0010, 4'b0010, 4'h5, 4'h0);
        rows   = 4'b0100;
        cols   = 4'b0001;
        change = 1'b1;
        tick();
        change = 1'b0;
        rows   = 4'b0010;
        cols   = 4'b0010;
        seen   = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (key_valid) seen = 1'b1;
        end
        check("held.busy", 32'(busy), 32'd1);
        check("held.no_valid", 32'(seen), 32'd0);
        release_key("held");
        check("held.key_new", 32'(key_new), 32'h5);
        press("key7", 4'b0100, 4'b0001, 4'h7, 4'h5);
        release_key("key7");

        // Non-one-hot patterns are ignored
        rows   = 4'b0001;
        cols   = 4'b0110;
        change = 1'b1;
        tick();
        change = 1'b0;
        check("invalid_cols.busy", 32'(busy), 32'd0);
        rows   = 4'b0000;
        cols   = 4'b0100;
        change = 1'b1;
        tick();
        change = 1'b0;
        check("invalid_rows.busy", 32'(busy), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (key_valid) seen = 1'b1;
        end
        check("invalid.no_valid", 32'(seen), 32'd0);
        check("invalid.key_new", 32'(key_new), 32'h7);

        // Reset in the middle of debounce
        press("key3", 4'b0001, 4'b0100, 4'h3, 4'h7);
        release_key("key3");
        press("keyA", 4'b0001, 4'b1000, 4'hA, 4'h3);
        release_key("keyA");
        rows   = 4'b0100;
        cols   = 4'b0100;
        change = 1'b1;
        tick();
        change = 1'b0;
        tick();
        check("mid_deb.pre_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_deb.key_new", 32'(key_new), 32'h0);
        check("mid_deb.key_old", 32'(key_old), 32'h0);
        check("mid_deb.busy", 32'(busy), 32'd0);
        check("mid_deb.valid", 32'(key_valid), 32'd0);

        // Reset while in COMMIT, with change asserted to confirm reset priority
        rows   = 4'b1000;
        cols   = 4'b1000;
        change = 1'b1;
        tick();
        change = 1'b0;
        n = 1;
        while (!key_valid && n < 20) begin
            tick();
            n++;
        end
        check("commit_rst.latency", n, 32'd5);
        reset  = 1'b1;
        change = 1'b1;
        tick();
        reset  = 1'b0;
        change = 1'b0;
        check("commit_rst.busy", 32'(busy), 32'd0);
        check("commit_rst.valid", 32'(key_valid), 32'd0);
        check("commit_rst.key_new", 32'(key_new), 32'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
